// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter and sequencer for the data RAM
// One access per grant: IDLE -> ACCESS -> DONE, or IDLE -> DONE for out-of-range addresses.
module dmem_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int ADDR_MAX = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_done,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_done,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          busy,
    output logic          ram_cs,
    output logic          ram_rw_n,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    localparam logic [AW-1:0] L_ADDR_MAX = AW'(ADDR_MAX);

    state_t        r_state;
    state_t        w_next;
    logic          r_last_gnt;
    logic          r_gnt;
    logic          r_we;

    logic          w_sel;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    logic          w_last_gnt;
    logic          w_gnt;
    logic          w_we;
    logic          w_ram_cs;
    logic          w_ram_rw_n;
    logic [AW-1:0] w_ram_addr;
    logic [DW-1:0] w_ram_wdata;
    logic [DW-1:0] w_rdata;
    logic          w_err;
    logic          w_p0_done;
    logic          w_p1_done;

    // On a tie the port that did not win last time is chosen.
    assign w_sel       = (p0_req && p1_req) ? ~r_last_gnt : p1_req;
    assign w_sel_we    = w_sel ? p1_we    : p0_we;
    assign w_sel_addr  = w_sel ? p1_addr  : p0_addr;
    assign w_sel_wdata = w_sel ? p1_wdata : p0_wdata;

    always_comb begin
        w_next      = r_state;
        w_last_gnt  = r_last_gnt;
        w_gnt       = r_gnt;
        w_we        = r_we;
        w_ram_cs    = 1'b0;
        w_ram_rw_n  = 1'b1;
        w_ram_addr  = ram_addr;
        w_ram_wdata = ram_wdata;
        w_rdata     = rdata;
        w_err       = 1'b0;
        w_p0_done   = 1'b0;
        w_p1_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (p0_req || p1_req) begin
                    w_gnt = w_sel;
                    w_we  = w_sel_we;
                    if (w_sel_addr <= L_ADDR_MAX) begin
                        w_next      = S_ACCESS;
                        w_ram_cs    = 1'b1;
                        w_ram_rw_n  = ~w_sel_we;
                        w_ram_addr  = w_sel_addr;
                        w_ram_wdata = w_sel_wdata;
                    end else begin
                        w_next    = S_DONE;
                        w_err     = 1'b1;
                        w_p0_done = ~w_sel;
                        w_p1_done = w_sel;
                    end
                end
            end
            S_ACCESS: begin
                w_next    = S_DONE;
                w_p0_done = ~r_gnt;
                w_p1_done = r_gnt;
                if (!r_we) begin
                    w_rdata = ram_rdata;
                end
            end
            S_DONE: begin
                w_next     = S_IDLE;
                w_last_gnt = r_gnt;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_last_gnt <= 1'b1;
            r_gnt      <= 1'b0;
            r_we       <= 1'b0;
            ram_cs     <= 1'b0;
            ram_rw_n   <= 1'b1;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            rdata      <= '0;
            err        <= 1'b0;
            p0_done    <= 1'b0;
            p1_done    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_last_gnt <= w_last_gnt;
            r_gnt      <= w_gnt;
            r_we       <= w_we;
            ram_cs     <= w_ram_cs;
            ram_rw_n   <= w_ram_rw_n;
            ram_addr   <= w_ram_addr;
            ram_wdata  <= w_ram_wdata;
            rdata      <= w_rdata;
            err        <= w_err;
            p0_done    <= w_p0_done;
            p1_done    <= w_p1_done;
            busy       <= (w_next != S_IDLE);
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        err;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [15:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
    logic        p0_done, p1_done, err, busy, ram_cs, ram_rw_n;
    logic [15:0] rdata, ram_addr, ram_wdata, ram_rdata;

    logic [7:0]  ram_mem [256];
    logic [7:0]  ref_mem [256];
    txn_t        q0[$];
    txn_t        q1[$];
    int          done_port[$];
    int          done_cyc[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [15:0] last_rd = '0;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_done(p0_done),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_done(p1_done),
        .rdata(rdata), .err(err), .busy(busy),
        .ram_cs(ram_cs), .ram_rw_n(ram_rw_n), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    assign ram_rdata = {ram_mem[ram_addr[7:0] + 8'd1], ram_mem[ram_addr[7:0]]};

    always @(posedge clk) begin
        if (ram_cs && !ram_rw_n) begin
            ram_mem[ram_addr[7:0]]        <= ram_wdata[7:0];
            ram_mem[ram_addr[7:0] + 8'd1] <= ram_wdata[15:8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_word(input logic [15:0] addr);
        logic [7:0] a;
        a = addr[7:0];
        return {ref_mem[a + 8'd1], ref_mem[a]};
    endfunction

    function automatic txn_t mk(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata; t.err = (addr > 16'd14);
        return t;
    endfunction

    // Scoreboard: pops the expected transaction of whichever port signals done.
    initial begin
        logic        prev_cs, cs_seen, acc_rw_n;
        logic [15:0] acc_addr, acc_wdata;
        txn_t        t;
        int          port;
        prev_cs = 1'b0; cs_seen = 1'b0; acc_rw_n = 1'b1; acc_addr = '0; acc_wdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_cs = 1'b0;
                cs_seen = 1'b0;
            end else begin
                if (ram_cs) begin
                    chk("cs_single_cycle", 32'(prev_cs), 32'd0);
                    cs_seen = 1'b1; acc_rw_n = ram_rw_n; acc_addr = ram_addr; acc_wdata = ram_wdata;
                end
                prev_cs = ram_cs;
                if (p0_done || p1_done) begin
                    chk("one_done", 32'(p0_done & p1_done), 32'd0);
                    port = p1_done ? 1 : 0;
                    done_port.push_back(port);
                    done_cyc.push_back(cyc);
                    if ((port == 1) ? (q1.size() == 0) : (q0.size() == 0)) begin
                        chk("unexpected_done", 32'(port), 32'hFFFF_FFFF);
                    end else begin
                        if (port == 1) t = q1.pop_front();
                        else           t = q0.pop_front();
                        chk("err", 32'(err), 32'(t.err));
                        chk("ram_touched", 32'(cs_seen), 32'(!t.err));
                        if (!t.err) begin
                            chk("acc_rw_n", 32'(acc_rw_n), 32'(!t.we));
                            chk("acc_addr", 32'(acc_addr), 32'(t.addr));
                            if (t.we) begin
                                chk("acc_wdata", 32'(acc_wdata), 32'(t.wdata));
                                ref_mem[t.addr[7:0]]        = t.wdata[7:0];
                                ref_mem[t.addr[7:0] + 8'd1] = t.wdata[15:8];
                            end else begin
                                last_rd = ref_word(t.addr);
                            end
                        end
                        chk("rdata", 32'(rdata), 32'(last_rd));
                    end
                    cs_seen = 1'b0;
                end
            end
        end
    end

    task automatic wait_done(input int port);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n = n + 1;
        end while (!((port == 1) ? p1_done : p0_done) && n < 40);
        chk("done_timeout", 32'((port == 1) ? p1_done : p0_done), 32'd1);
    endtask

    task automatic drive(input int port, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
        if (port == 1) begin
            p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
            q1.push_back(mk(we, addr, wdata));
        end else begin
            p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
            q0.push_back(mk(we, addr, wdata));
        end
    endtask

    task automatic do_txn(input int port, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
        int start;
        @(posedge clk); #1;
        start = cyc;
        drive(port, we, addr, wdata);
        wait_done(port);
        chk("latency", 32'(cyc - start), (addr > 16'd14) ? 32'd1 : 32'd2);
        if (port == 1) p1_req = 1'b0;
        else           p0_req = 1'b0;
    endtask

    task automatic stream(input int port);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            if (port == 1) drive(1, 1'b0, 16'(8 + 2 * i), 16'h0);
            else           drive(0, 1'b1, 16'(2 * i), 16'(16'h1100 + i));
            wait_done(port);
        end
        if (port == 1) p1_req = 1'b0;
        else           p0_req = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; p0_req = 1'b0; p1_req = 1'b0;
        q0.delete(); q1.delete();
        last_rd = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 8'(i * 17) ^ 8'h3C;
            ref_mem[i] = 8'(i * 17) ^ 8'h3C;
        end

        // Reset held with both ports requesting.
        rst_n = 1'b0;
        p0_we = 1'b0; p0_addr = 16'd2; p0_req = 1'b1;
        p1_we = 1'b0; p1_addr = 16'd6; p1_req = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("rst_ram_cs", 32'(ram_cs), 32'd0);
        chk("rst_ram_rw_n", 32'(ram_rw_n), 32'd1);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_p0_done", 32'(p0_done), 32'd0);
        chk("rst_p1_done", 32'(p1_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        q0.push_back(mk(1'b0, 16'd2, 16'h0));
        q1.push_back(mk(1'b0, 16'd6, 16'h0));
        done_port.delete(); done_cyc.delete();
        @(negedge clk);
        rst_n = 1'b1;
        c = cyc;
        @(negedge clk);
        chk("first_cs", 32'(ram_cs), 32'd1);
        chk("first_addr", 32'(ram_addr), 32'd2);
        chk("first_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("first_p0_done", 32'(p0_done), 32'd1);
        chk("first_p1_done", 32'(p1_done), 32'd0);
        p0_req = 1'b0;
        wait_done(1);
        p1_req = 1'b0;
        chk("first_done_cyc", 32'(done_cyc[0]), 32'(c + 2));

        // Port 0 write then read back.
        do_txn(0, 1'b1, 16'd4, 16'hA55A);
        do_txn(0, 1'b0, 16'd4, 16'h0);
        chk("readback", 32'(rdata), 32'hA55A);

        // Boundary and out-of-range addresses on port 1.
        do_txn(1, 1'b0, 16'd14, 16'h0);
        do_txn(1, 1'b0, 16'd15, 16'h0);
        do_txn(1, 1'b0, 16'hFFFF, 16'h0);
        do_txn(1, 1'b1, 16'h8000, 16'hDEAD);

        // Continuous contention from reset: strict alternation every 3 cycles.
        do_reset();
        done_port.delete(); done_cyc.delete();
        fork
            stream(0);
            stream(1);
        join
        chk("rr_count", 32'(done_port.size()), 32'd6);
        for (int i = 0; i < done_port.size(); i++) begin
            chk("rr_port", 32'(done_port[i]), 32'(i % 2));
            if (i > 0) chk("rr_spacing", 32'(done_cyc[i] - done_cyc[i-1]), 32'd3);
        end

        // Reset during the ACCESS cycle of a write.
        @(posedge clk); #1;
        p0_we = 1'b1; p0_addr = 16'd6; p0_wdata = 16'h1234; p0_req = 1'b1;
        @(posedge clk); #2;
        chk("mid_cs_before", 32'(ram_cs), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_cs_after", 32'(ram_cs), 32'd0);
        chk("mid_rw_n_after", 32'(ram_rw_n), 32'd1);
        chk("mid_busy_after", 32'(busy), 32'd0);
        p0_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_no_done", 32'(p0_done | p1_done), 32'd0);
        chk("mid_mem_lo", 32'(ram_mem[6]), 32'(ref_mem[6]));
        chk("mid_mem_hi", 32'(ram_mem[7]), 32'(ref_mem[7]));
        rst_n = 1'b1;

        // Port 0 holds req across done; port 1 joins later and must still be served.
        done_port.delete(); done_cyc.delete();
        @(posedge clk); #1;
        c = cyc;
        drive(0, 1'b0, 16'd8, 16'h0);
        q0.push_back(mk(1'b0, 16'd8, 16'h0));
        q0.push_back(mk(1'b0, 16'd8, 16'h0));
        repeat (4) @(posedge clk); #1;
        drive(1, 1'b0, 16'd10, 16'h0);
        wait_done(1);
        p1_req = 1'b0;
        wait_done(0);
        p0_req = 1'b0;
        chk("hold_count", 32'(done_port.size()), 32'd4);
        for (int i = 0; i < done_port.size() && i < 4; i++) begin
            chk("hold_port", 32'(done_port[i]), (i == 2) ? 32'd1 : 32'd0);
            chk("hold_cyc", 32'(done_cyc[i]), 32'(c + 2 + 3 * i));
        end

        repeat (4) @(negedge clk);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
